// File: rtl/eth_pkg.sv
// ----------------------------------------------------------------------------
// eth_pkg
// Shared definitions for the Ethernet receive decoder.
//   state_t        - receive state machine encoding
//   PREAMBLE_NIB   - preamble nibble value (0x5)
//   SFD_NIB        - last nibble of the start-of-frame delimiter (0xD)
//   CRC_POLY       - reflected CRC-32 polynomial
//   CRC_INIT       - CRC register start value
//   CRC_RESIDUE    - good-frame residue, written in normal (MSB-first) bit order
//   bit_rev32()    - reverses the bit order of a 32-bit word
// ----------------------------------------------------------------------------
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } state_t;

  localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  SFD_NIB      = 4'hD;
  localparam logic [31:0] CRC_POLY     = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE  = 32'hC704_DD7B;

  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// ----------------------------------------------------------------------------
// crc32_d8
// Combinational byte-wide CRC-32 next-state function (reflected, LSB first).
// The CRC register itself lives in the parent.
// Only built when ETH_RX_FCS_CHECK_EN is defined.
//   i_crc  [31:0] - current CRC register value
//   i_data [7:0]  - byte to absorb
//   o_crc  [31:0] - CRC register value after absorbing i_data
// ----------------------------------------------------------------------------
`ifdef ETH_RX_FCS_CHECK_EN
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] w_c;

  always_comb begin
    w_c = i_crc ^ {24'h0, i_data};
    for (int i = 0; i < 8; i++) begin
      w_c = w_c[0] ? ((w_c >> 1) ^ CRC_POLY) : (w_c >> 1);
    end
    o_crc = w_c;
  end

endmodule
`endif

// File: rtl/eth_rx_decoder.sv
// ----------------------------------------------------------------------------
// eth_rx_decoder
// Converts an SDR-captured RGMII nibble stream into a byte stream with
// frame-end and frame-error marking. Strips preamble/SFD, checks runt,
// oversize and odd-nibble endings, and optionally the FCS.
// Optional feature macro: ETH_RX_FCS_CHECK_EN (CRC-32 FCS check).
//
// Parameters
//   MAX_LEN  - largest accepted frame length in bytes (DA through FCS)
//   MIN_LEN  - smallest frame length not flagged as a runt
// Ports
//   clk            - system clock
//   rstn           - asynchronous active-low reset
//   rgmii_rxd[3:0] - receive nibble
//   rgmii_rx_ctrl  - receive data valid
//   o_data[7:0]    - received byte (holds when o_valid=0)
//   o_valid        - o_data valid strobe
//   o_last         - last byte of frame (with o_valid)
//   o_err          - frame error (with o_valid & o_last)
//   o_frame_cnt    - count of error-free frames, wrapping
// ----------------------------------------------------------------------------
module eth_rx_decoder
  import eth_pkg::*;
#(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  rgmii_rxd,
  input  logic        rgmii_rx_ctrl,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_last,
  output logic        o_err,
  output logic [15:0] o_frame_cnt
);

  localparam logic [10:0] LP_MAX = 11'(MAX_LEN);
  localparam logic [10:0] LP_MIN = 11'(MIN_LEN);

  state_t      r_state;
  logic [3:0]  r_lo;          // first (low) nibble of the byte in progress
  logic        r_half;        // a low nibble is pending
  logic [7:0]  r_skid;        // last completed byte, not yet emitted
  logic        r_have;        // r_skid holds a byte of this frame
  logic [10:0] r_cnt;         // completed bytes in this frame, saturating
  logic        r_wait_idle;   // set by reset: ignore traffic until ctrl=0
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_last;
  logic        r_err;
  logic [15:0] r_frame_cnt;

  logic [7:0]  w_byte;
  logic [10:0] w_cnt_inc;
  logic        w_fcs_bad;
  logic        w_end_err;

  assign w_byte    = {rgmii_rxd, r_lo};
  assign w_cnt_inc = (r_cnt == 11'h7FF) ? r_cnt : (r_cnt + 11'd1);

`ifdef ETH_RX_FCS_CHECK_EN
  logic [31:0] r_crc;
  logic [31:0] w_crc_next;

  crc32_d8 u_crc32_d8 (
    .i_crc  (r_crc),
    .i_data (w_byte),
    .o_crc  (w_crc_next)
  );

  // The register runs reflected; the residue constant is in normal bit order.
  assign w_fcs_bad = (bit_rev32(r_crc) != CRC_RESIDUE);
`else
  assign w_fcs_bad = 1'b0;
`endif

  assign w_end_err = r_half | (r_cnt < LP_MIN) | ~r_have | w_fcs_bad;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_lo        <= 4'h0;
      r_half      <= 1'b0;
      r_skid      <= 8'h00;
      r_have      <= 1'b0;
      r_cnt       <= 11'd0;
      r_wait_idle <= 1'b1;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_err       <= 1'b0;
      r_frame_cnt <= 16'h0000;
`ifdef ETH_RX_FCS_CHECK_EN
      r_crc       <= 32'h0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;

      if (r_valid & r_last & ~r_err) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end

      if (!rgmii_rx_ctrl) begin
        r_wait_idle <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (rgmii_rx_ctrl) begin
            // After a reset the line may be mid-frame; treat it as junk.
            if (!r_wait_idle && rgmii_rxd == PREAMBLE_NIB) begin
              r_state <= PREAMBLE;
            end else begin
              r_state <= DROP;
            end
          end
        end

        PREAMBLE: begin
          if (!rgmii_rx_ctrl) begin
            r_state <= IDLE;
          end else if (rgmii_rxd == PREAMBLE_NIB) begin
            r_state <= PREAMBLE;
          end else if (rgmii_rxd == SFD_NIB) begin
            r_state <= DATA;
            r_half  <= 1'b0;
            r_have  <= 1'b0;
            r_cnt   <= 11'd0;
`ifdef ETH_RX_FCS_CHECK_EN
            r_crc   <= CRC_INIT;
`endif
          end else begin
            r_state <= DROP;
          end
        end

        DATA: begin
          if (!rgmii_rx_ctrl) begin
            // Frame end: flush the held byte (or 0x00 if none) as last.
            r_valid <= 1'b1;
            r_last  <= 1'b1;
            r_err   <= w_end_err;
            r_data  <= r_have ? r_skid : 8'h00;
            r_state <= IDLE;
          end else if (!r_half) begin
            r_lo   <= rgmii_rxd;
            r_half <= 1'b1;
          end else begin
            r_half <= 1'b0;
`ifdef ETH_RX_FCS_CHECK_EN
            r_crc  <= w_crc_next;
`endif
            if (r_have) begin
              r_valid <= 1'b1;
              r_data  <= r_skid;
            end
            if (r_cnt == LP_MAX) begin
              // Byte MAX_LEN+1 arrived: close the frame as oversize.
              r_last  <= 1'b1;
              r_err   <= 1'b1;
              r_have  <= 1'b0;
              r_state <= DROP;
            end else begin
              r_skid <= w_byte;
              r_have <= 1'b1;
              r_cnt  <= w_cnt_inc;
            end
          end
        end

        DROP: begin
          if (!rgmii_rx_ctrl) begin
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_last      = r_last;
  assign o_err       = r_err;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_eth_rx_decoder.sv
// ----------------------------------------------------------------------------
// tb_eth_rx_decoder
// Directed bench for eth_rx_decoder: good frame, corrupted FCS, bad SFD,
// oversize, odd nibble, and reset in the middle of a frame.
// ----------------------------------------------------------------------------
module tb_eth_rx_decoder;

`ifdef ETH_RX_FCS_CHECK_EN
  localparam bit FCS_EN = 1'b1;
`else
  localparam bit FCS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  rgmii_rxd = 4'h0;
  logic        rgmii_rx_ctrl = 1'b0;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_last;
  logic        o_err;
  logic [15:0] o_frame_cnt;

  eth_rx_decoder #(.MAX_LEN(1518), .MIN_LEN(64)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .rgmii_rxd     (rgmii_rxd),
    .rgmii_rx_ctrl (rgmii_rx_ctrl),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .o_last        (o_last),
    .o_err         (o_err),
    .o_frame_cnt   (o_frame_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] fr [0:2047];
  int         fr_len;

  int   pulse_cnt = 0;
  int   last_cnt  = 0;
  int   last_idx  = -1;
  int   data_bad  = 0;
  logic last_err  = 1'b0;

  int   checks = 0;
  int   fails  = 0;
  int   exp_fc = 0;

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      if (pulse_cnt < 2048 && o_data !== fr[pulse_cnt]) data_bad = data_bad + 1;
      if (o_last === 1'b1) begin
        last_cnt = last_cnt + 1;
        last_idx = pulse_cnt;
        last_err = o_err;
      end
      pulse_cnt = pulse_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("check %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_mon();
    pulse_cnt = 0;
    last_cnt  = 0;
    last_idx  = -1;
    data_bad  = 0;
    last_err  = 1'b0;
  endtask

  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, fr[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Fill fr with a pattern; optionally the last four bytes are a valid FCS.
  task automatic build(input int len, input int seed, input bit with_fcs);
    logic [31:0] f;
    int np;
    np = with_fcs ? len - 4 : len;
    for (int i = 0; i < np; i++) fr[i] = 8'(i * 7 + seed);
    if (with_fcs) begin
      f = fcs_of(np);
      fr[np]   = f[7:0];
      fr[np+1] = f[15:8];
      fr[np+2] = f[23:16];
      fr[np+3] = f[31:24];
    end
    fr_len = len;
  endtask

  task automatic drive(input logic ctrl, input logic [3:0] nib);
    @(posedge clk);
    #1;
    rgmii_rx_ctrl = ctrl;
    rgmii_rxd     = nib;
  endtask

  task automatic send_pre(input logic [3:0] sfd);
    for (int i = 0; i < 15; i++) drive(1'b1, 4'h5);
    drive(1'b1, sfd);
  endtask

  task automatic send_bytes(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      drive(1'b1, fr[i][3:0]);
      drive(1'b1, fr[i][7:4]);
    end
  endtask

  task automatic send_end(input bit extra_nib);
    if (extra_nib) drive(1'b1, 4'hA);
    for (int i = 0; i < 6; i++) drive(1'b0, 4'h0);
  endtask

  task automatic frame_summary(input string name);
    $display("frame %s: pulses=%0d lasts=%0d last_idx=%0d err=%0b data_bad=%0d cnt=%0d",
             name, pulse_cnt, last_cnt, last_idx, last_err, data_bad, o_frame_cnt);
  endtask

  initial begin
    #2;
    check("rst_valid", {31'h0, o_valid}, 32'd0);
    check("rst_last",  {31'h0, o_last},  32'd0);
    check("rst_err",   {31'h0, o_err},   32'd0);
    check("rst_data",  {24'h0, o_data},  32'd0);
    check("rst_cnt",   {16'h0, o_frame_cnt}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);

    // Good 64-byte frame
    build(64, 1, 1'b1);
    clear_mon();
    send_pre(4'hD); send_bytes(0, 63); send_end(1'b0);
    frame_summary("good64");
    exp_fc = 1;
    check("a_pulses", pulse_cnt, 32'd64);
    check("a_lasts",  last_cnt,  32'd1);
    check("a_lastidx", last_idx, 32'd63);
    check("a_err",    {31'h0, last_err}, 32'd0);
    check("a_data",   data_bad,  32'd0);
    check("a_cnt",    {16'h0, o_frame_cnt}, exp_fc);

    // Same frame, one payload bit flipped
    build(64, 1, 1'b1);
    fr[10] = fr[10] ^ 8'h01;
    clear_mon();
    send_pre(4'hD); send_bytes(0, 63); send_end(1'b0);
    frame_summary("flip");
    if (!FCS_EN) exp_fc = exp_fc + 1;
    check("b_pulses", pulse_cnt, 32'd64);
    check("b_err",    {31'h0, last_err}, {31'h0, FCS_EN});
    check("b_data",   data_bad,  32'd0);
    check("b_cnt",    {16'h0, o_frame_cnt}, exp_fc);

    // Bad SFD, then 70 bytes: dropped
    build(70, 3, 1'b0);
    clear_mon();
    send_pre(4'h3); send_bytes(0, 69); send_end(1'b0);
    frame_summary("badsfd");
    check("c_pulses", pulse_cnt, 32'd0);
    check("c_cnt",    {16'h0, o_frame_cnt}, exp_fc);

    // Next good frame decodes normally
    build(64, 5, 1'b1);
    clear_mon();
    send_pre(4'hD); send_bytes(0, 63); send_end(1'b0);
    frame_summary("good_after");
    exp_fc = exp_fc + 1;
    check("d_pulses", pulse_cnt, 32'd64);
    check("d_err",    {31'h0, last_err}, 32'd0);
    check("d_data",   data_bad,  32'd0);
    check("d_cnt",    {16'h0, o_frame_cnt}, exp_fc);

    // Oversize 1600-byte frame
    build(1600, 9, 1'b0);
    clear_mon();
    send_pre(4'hD); send_bytes(0, 1599); send_end(1'b0);
    frame_summary("over1600");
    check("e_pulses", pulse_cnt, 32'd1518);
    check("e_lasts",  last_cnt,  32'd1);
    check("e_lastidx", last_idx, 32'd1517);
    check("e_err",    {31'h0, last_err}, 32'd1);
    check("e_data",   data_bad,  32'd0);
    check("e_cnt",    {16'h0, o_frame_cnt}, exp_fc);

    // 65 bytes plus one extra nibble
    build(65, 2, 1'b1);
    clear_mon();
    send_pre(4'hD); send_bytes(0, 64); send_end(1'b1);
    frame_summary("odd_nib");
    check("f_pulses", pulse_cnt, 32'd65);
    check("f_lastidx", last_idx, 32'd64);
    check("f_err",    {31'h0, last_err}, 32'd1);
    check("f_cnt",    {16'h0, o_frame_cnt}, exp_fc);

    // Reset in the middle of a frame at byte 30
    build(64, 4, 1'b1);
    clear_mon();
    send_pre(4'hD); send_bytes(0, 29);
    rstn = 1'b0;
    #1;
    check("g_rst_valid", {31'h0, o_valid}, 32'd0);
    check("g_rst_data",  {24'h0, o_data},  32'd0);
    check("g_rst_cnt",   {16'h0, o_frame_cnt}, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    clear_mon();
    send_bytes(30, 63); send_end(1'b0);
    frame_summary("after_rst");
    check("g_pulses", pulse_cnt, 32'd0);

    build(64, 6, 1'b1);
    clear_mon();
    send_pre(4'hD); send_bytes(0, 63); send_end(1'b0);
    frame_summary("good_post_rst");
    check("h_pulses", pulse_cnt, 32'd64);
    check("h_err",    {31'h0, last_err}, 32'd0);
    check("h_cnt",    {16'h0, o_frame_cnt}, 32'd1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/eth_rx_decoder.md
ETH_RX_DECODER -- requirements
Module: eth_rx_decoder

Interface
REQ-001 SHALL have parameter MAX_LEN, default 1518, meaning the largest accepted frame length in bytes, counted from the destination address through the FCS.
REQ-002 SHALL have parameter MIN_LEN, default 64, meaning the smallest frame length in bytes that is not flagged as a runt.
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; all logic is in this domain.
REQ-004 SHALL have port rstn, input, 1 bit, an asynchronous active-low reset.
REQ-005 SHALL have port rgmii_rxd, input, 4 bits, the receive nibble, already captured single-data-rate into the clk domain.
REQ-006 SHALL have port rgmii_rx_ctrl, input, 1 bit, receive data valid.
REQ-007 SHALL have port o_data, output, 8 bits, the received byte.
REQ-008 SHALL have port o_valid, output, 1 bit; o_data is valid on any cycle where o_valid is high.
REQ-009 SHALL have port o_last, output, 1 bit, marking the final byte of a frame; it is qualified by o_valid.
REQ-010 SHALL have port o_err, output, 1 bit, a frame-error flag; it is qualified by o_valid and o_last.
REQ-011 SHALL have port o_frame_cnt, output, 16 bits, the count of frames completed without error.

Function
REQ-012 SHALL implement a state machine with states IDLE, PREAMBLE, DATA and DROP.
REQ-013 SHALL move IDLE to PREAMBLE when rgmii_rx_ctrl=1 and rgmii_rxd=0x5.
REQ-014 SHALL move IDLE to DROP when rgmii_rx_ctrl=1 and rgmii_rxd is any value other than 0x5.
REQ-015 SHALL, in PREAMBLE, stay in PREAMBLE on nibble 0x5, move to DATA on nibble 0xD (SFD complete), and move to DROP on any other nibble.
REQ-016 SHALL return to IDLE from PREAMBLE when rgmii_rx_ctrl=0; no output is produced.
REQ-017 SHALL, in DATA, assemble bytes low nibble first: byte = {second nibble, first nibble}.
REQ-018 SHALL hold each completed byte in a one-byte skid register.
REQ-019 SHALL emit the held byte with o_valid=1 and o_last=0 on the cycle after the next byte completes.
REQ-020 SHALL, on the first cycle in DATA with rgmii_rx_ctrl=0, emit the held byte on the following cycle with o_valid=1 and o_last=1, then return to IDLE.
REQ-021 SHALL assert o_err with o_last when the frame ends on an odd nibble count.
REQ-022 SHALL assert o_err with o_last when the frame length is below MIN_LEN bytes.
REQ-023 SHALL assert o_err with o_last when the frame ends with no complete byte; in that case o_data=0x00.
REQ-024 SHALL treat byte MAX_LEN+1 as oversize: emit byte MAX_LEN with o_last=1 and o_err=1, then enter DROP.
REQ-025 SHALL, in DROP, produce no output and return to IDLE on rgmii_rx_ctrl=0.
REQ-026 SHALL keep o_valid, o_last and o_err as single-cycle pulses; o_data holds its last value when o_valid=0.
REQ-027 SHALL increment o_frame_cnt by 1 on every cycle with o_valid & o_last & ~o_err, wrapping 0xFFFF to 0x0000.
REQ-028 SHALL keep the byte counter 11 bits wide and saturating.

Reset
REQ-029 SHALL, while rstn=0, asynchronously force state=IDLE, o_data=0x00, o_valid=0, o_last=0, o_err=0, o_frame_cnt=0, the skid register and CRC cleared.
REQ-030 SHALL, on reset deassertion mid-frame, remain in DROP-equivalent behaviour until rgmii_rx_ctrl is sampled 0; the partial frame is never emitted.

Configuration
REQ-031 SHALL, when ETH_RX_FCS_CHECK_EN is defined, run a CRC-32 over every DATA byte including the FCS, using the reflected polynomial 0xEDB88320, init 0xFFFFFFFF and no final inversion.
REQ-032 SHALL, when ETH_RX_FCS_CHECK_EN is defined, assert o_err with o_last if the final residue is not 0xC704DD7B.
REQ-033 SHALL, when ETH_RX_FCS_CHECK_EN is undefined, omit all CRC logic; o_err then reflects only REQ-021 through REQ-024.

Structure
REQ-034 SHALL place in the shared package eth_pkg: the state enum, and the constants PREAMBLE_NIB=0x5, SFD_NIB=0xD, CRC_POLY, CRC_INIT and CRC_RESIDUE.
REQ-035 SHALL implement the byte-wide CRC update as the sub-module crc32_d8 (combinational next-state, CRC register in the parent).

Verification
REQ-036 SHALL cover: 15 nibbles 0x5, then 0xD, then a 64-byte frame with a correct FCS -> 64 o_valid pulses, o_last on the 64th, o_err=0, o_frame_cnt=1.
REQ-037 SHALL cover: the same frame with one payload bit flipped -> o_last with o_err=1 when ETH_RX_FCS_CHECK_EN is defined, and o_err=0 when it is undefined; o_frame_cnt unchanged with the macro defined.
REQ-038 SHALL cover: preamble, then nibble 0x3 instead of 0xD, then 70 bytes -> no o_valid pulses; the next good frame is decoded normally.
REQ-039 SHALL cover: a 1600-byte frame -> exactly 1518 o_valid pulses, o_last=1 and o_err=1 on pulse 1518, and DROP until rgmii_rx_ctrl=0.
REQ-040 SHALL cover: a 65-byte frame plus one extra nibble -> o_last with o_err=1.
REQ-041 SHALL cover: rstn pulsed low at byte 30 of a frame -> outputs 0 immediately, no further pulses for that frame, and the next frame decoded with o_frame_cnt=1.
